// File: rtl/pm_iter.sv
// Iterative radix-4 (2-bit digit) shift-add multiplier with valid/ready handshakes.
// Optional two's-complement operation is enabled by defining PM_ITER_SIGNED_EN.
module pm_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] res;
  logic [CW-1:0]      cnt;
  logic               calc_done;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef PM_ITER_SIGNED_EN
  logic sign;

  // Magnitudes are taken as unsigned, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign res   = sign ? (~acc + 1'b1) : acc;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign res   = acc;
`endif

  // The final CALC cycle only transfers the finished accumulator into p.
  assign calc_done = (cnt == CW'(DIGITS));
  assign pp = (b_sh[0] ? a_sh : '0) + (b_sh[1] ? (a_sh << 1) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (calc_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      p    <= '0;
`ifdef PM_ITER_SIGNED_EN
      sign <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= {{WIDTH{1'b0}}, a_mag};
            b_sh <= b_mag;
            acc  <= '0;
            cnt  <= '0;
`ifdef PM_ITER_SIGNED_EN
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        CALC: begin
          if (calc_done) begin
            p <= res;
          end else begin
            acc  <= acc + pp;
            a_sh <= a_sh << 2;
            b_sh <= b_sh >> 2;
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_iter.sv
// Directed bench for pm_iter: WIDTH=8 vectors, backpressure, reset abort, WIDTH=4 exhaustive.
module tb_pm_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pm_iter #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  pm_iter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp4(input logic [3:0] x, input logic [3:0] y);
    logic signed [7:0] r;
`ifdef PM_ITER_SIGNED_EN
    r = $signed(x) * $signed(y);
`else
    r = {4'b0, x} * {4'b0, y};
`endif
    return r;
  endfunction

  // Waits (bounded) for out_valid after the accept edge; returns cycles from accept.
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp, input string tag);
    int guard;
    int n;
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, " accept"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(n);
    check_eq({tag, " latency"}, n, 5);
    check_eq({tag, " p"}, p, exp);
    $display("[TB] %s: 0x%02h * 0x%02h -> p=0x%04h after %0d cycles", tag, ta, tb_v, p, n);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, " valid drop"}, out_valid, 1'b0);
  endtask

  initial begin
    int n;
    int got;
    int cyc;
    logic [7:0] exp_q[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0;
    #12;
    check_eq("rst in_ready", in_ready, 1'b1);
    check_eq("rst out_valid", out_valid, 1'b0);
    check_eq("rst p", p, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'd15, 8'd13, 16'h00C3, "15x13");
    run_op(8'd0, 8'hA5, 16'h0000, "0xA5");
`ifdef PM_ITER_SIGNED_EN
    run_op(8'h80, 8'h80, 16'h4000, "-128x-128");
    run_op(8'hFD, 8'h05, 16'hFFF1, "-3x5");
    run_op(8'h7F, 8'hFF, 16'hFF81, "127x-1");
`else
    run_op(8'd255, 8'd255, 16'hFE01, "255x255");
`endif

    // Backpressure: result held while a new pair is offered.
    @(negedge clk);
    a = 8'd18; b = 8'd52; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(n);
    check_eq("bp latency", n, 5);
    a = 8'd7; b = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp out_valid hold", out_valid, 1'b1);
      check_eq("bp p hold", p, 16'h03A8);
      check_eq("bp in_ready low", in_ready, 1'b0);
      @(negedge clk);
    end
    $display("[TB] backpressure: p=0x%04h held 10 cycles", p);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp after hs out_valid", out_valid, 1'b0);
    check_eq("bp after hs in_ready", in_ready, 1'b1);
    check_eq("bp p kept", p, 16'h03A8);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp new accepted", in_ready, 1'b0);
    wait_result(n);
    check_eq("bp2 latency", n, 5);
    check_eq("bp2 p", p, 16'h003F);
    $display("[TB] backpressure follow-up: 7*9 -> p=0x%04h", p);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset two digit cycles into 200*100.
    a = 8'd200; b = 8'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst out_valid", out_valid, 1'b0);
    check_eq("midrst p", p, 16'h0000);
    check_eq("midrst in_ready", in_ready, 1'b1);
    $display("[TB] reset mid-CALC: p=0x%04h out_valid=%0d", p, out_valid);
    @(negedge clk);
    rst = 1'b0;
    check_eq("postrst out_valid", out_valid, 1'b0);
    run_op(8'd3, 8'd7, 16'h0015, "3x7");

    // WIDTH=4 exhaustive, back to back.
    got = 0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          int guard;
          @(negedge clk);
          a4 = i[7:4]; b4 = i[3:0]; in_valid4 = 1'b1;
          guard = 0;
          while (!in_ready4 && guard < 20) begin
            @(negedge clk);
            guard++;
          end
          exp_q.push_back(exp4(i[7:4], i[3:0]));
        end
        @(negedge clk);
        in_valid4 = 1'b0;
      end
      begin
        cyc = 0;
        while (got < 256 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (out_valid4) begin
            if (exp_q.size() == 0) begin
              check_eq("w4 spurious result", 1'b1, 1'b0);
            end else begin
              check_eq("w4 p", p4, exp_q.pop_front());
            end
            got++;
          end
        end
      end
    join
    check_eq("w4 result count", got, 256);
    check_eq("w4 leftover", exp_q.size(), 0);
    $display("[TB] width4 exhaustive: %0d results collected", got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
